// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command wrapper: FSM state encodings,
// command opcodes and a byte-insertion helper for the 24-bit command word.
package cmd_pkg;

    typedef enum logic [1:0] {
        RX_WAIT_B1 = 2'd0,
        RX_WAIT_B2 = 2'd1,
        RX_WAIT_B3 = 2'd2,
        RX_HOLD    = 2'd3
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_WRITE  = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h07;
    localparam logic [7:0] OP_NOP    = 8'h09;

    // Byte 0 lands in [23:16], byte 1 in [15:8], byte 2 in [7:0].
    function automatic logic [23:0] put_byte(input logic [23:0] cmd,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [23:0] v;
        v = cmd;
        case (idx)
            2'd0:    v[23:16] = b;
            2'd1:    v[15:8]  = b;
            default: v[7:0]   = b;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/resp_queue.sv
// Response transmit path: one-entry pending buffer in front of the UART
// transmitter, with a same-cycle bypass when idle and empty.
module resp_queue
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent,
    output logic       resp_ovf
);

    tx_state_e  r_state;
    logic       r_pend_vld;
    logic [7:0] r_pend_data;
    logic [7:0] r_tx_data;
    logic       r_trmt;
    logic       r_ovf;

    assign resp_sent = (r_state == TX_BUSY) && tx_done;
    assign trmt      = r_trmt;
    assign tx_data   = r_tx_data;
    assign resp_ovf  = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= TX_IDLE;
            r_pend_vld  <= 1'b0;
            r_pend_data <= 8'h00;
            r_tx_data   <= 8'h00;
            r_trmt      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_trmt <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (r_pend_vld) begin
                        // Pop and refill in the same cycle: a new request is never dropped here.
                        r_tx_data  <= r_pend_data;
                        r_trmt     <= 1'b1;
                        r_state    <= TX_BUSY;
                        r_pend_vld <= send_resp;
                        if (send_resp) begin
                            r_pend_data <= resp_data;
                        end
                    end else if (send_resp) begin
                        r_tx_data <= resp_data;
                        r_trmt    <= 1'b1;
                        r_state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (send_resp) begin
                        if (!r_pend_vld) begin
                            r_pend_vld  <= 1'b1;
                            r_pend_data <= resp_data;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                    if (tx_done) begin
                        r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte commands from a UART receiver with an inter-byte timeout,
// and queues single-byte responses to the UART transmitter.
module uart_cmd_wrapper
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        resp_sent,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_ovf
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rx_state_e        r_rx_state;
    logic [23:0]      r_cmd;
    logic             r_cmd_rdy;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic w_mid_cmd;
    logic w_tmo;

    assign w_mid_cmd  = (r_rx_state == RX_WAIT_B2) || (r_rx_state == RX_WAIT_B3);
    assign w_tmo      = w_mid_cmd && (r_tmo_cnt == TMO_LAST);
    assign clr_rx_rdy = rx_rdy && (r_rx_state != RX_HOLD);
    assign cmd        = r_cmd;
    assign cmd_rdy    = r_cmd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_WAIT_B1;
            r_cmd      <= 24'h000000;
            r_cmd_rdy  <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_rx_state)
                RX_WAIT_B1: begin
                    if (rx_rdy) begin
                        r_cmd      <= put_byte(r_cmd, 2'd0, rx_data);
                        r_rx_state <= RX_WAIT_B2;
                        r_tmo_cnt  <= '0;
                    end
                end
                RX_WAIT_B2, RX_WAIT_B3: begin
                    if (rx_rdy) begin
                        r_tmo_cnt <= '0;
                        // A byte arriving on the timeout cycle starts a fresh command.
                        if (w_tmo) begin
                            r_cmd      <= put_byte(r_cmd, 2'd0, rx_data);
                            r_rx_state <= RX_WAIT_B2;
                        end else if (r_rx_state == RX_WAIT_B2) begin
                            r_cmd      <= put_byte(r_cmd, 2'd1, rx_data);
                            r_rx_state <= RX_WAIT_B3;
                        end else begin
                            r_cmd      <= put_byte(r_cmd, 2'd2, rx_data);
                            r_rx_state <= RX_HOLD;
                            r_cmd_rdy  <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_rx_state <= RX_WAIT_B1;
                        r_tmo_cnt  <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                RX_HOLD: begin
                    if (clr_cmd_rdy) begin
                        r_cmd_rdy  <= 1'b0;
                        r_rx_state <= RX_WAIT_B1;
                    end
                end
                default: r_rx_state <= RX_WAIT_B1;
            endcase
        end
    end

    resp_queue u_resp_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp_data (resp_data),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent),
        .resp_ovf  (resp_ovf)
    );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: transaction-level model of command assembly and
// response queueing, checked every cycle, plus literal scenario expectations.
module tb_uart_cmd_wrapper;

    localparam int unsigned T = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        resp_sent;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        resp_ovf;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp_data   (resp_data),
        .resp_sent   (resp_sent),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_ovf    (resp_ovf)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: bytes collected, cycle of last accepted byte, command image.
    int          m_nb;
    int          m_last;
    logic [23:0] m_cmd;
    logic        m_rdy;
    // Model: transmitter busy, pending queue, next-cycle trmt/tx_data, overflow.
    logic        m_busy;
    logic [7:0]  m_pend[$];
    logic        m_trmt;
    logic [7:0]  m_tx;
    logic        m_ovf;

    logic [7:0]  rxq[$];
    int          n_clr;
    int          n_sent;
    logic [7:0]  trmt_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_nb = 0; m_last = 0; m_cmd = 24'h0; m_rdy = 1'b0;
        m_busy = 1'b0; m_pend.delete(); m_trmt = 1'b0; m_tx = 8'h00; m_ovf = 1'b0;
    endtask

    // One clock: drive receiver, compare outputs at negedge, advance model.
    task automatic cycle();
        logic       exp_clr, exp_sent, expired, accept, launched, direct;
        logic [7:0] lval;
        int         eff;
        rx_rdy  = (rxq.size() > 0);
        rx_data = rx_rdy ? rxq[0] : 8'h00;
        @(negedge clk);
        chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
        if (m_rdy) chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("trmt", 32'(trmt), 32'(m_trmt));
        if (m_busy) chk("tx_data", 32'(tx_data), 32'(m_tx));
        chk("resp_ovf", 32'(resp_ovf), 32'(m_ovf));

        expired  = (m_nb == 1 || m_nb == 2) && (cyc - m_last >= int'(T));
        eff      = expired ? 0 : m_nb;
        exp_clr  = rx_rdy && (eff != 3);
        exp_sent = m_busy && tx_done;
        chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(exp_clr));
        chk("resp_sent", 32'(resp_sent), 32'(exp_sent));
        if (clr_rx_rdy) n_clr++;
        if (resp_sent) n_sent++;
        if (trmt) trmt_log.push_back(tx_data);

        if (eff == 3) begin
            if (clr_cmd_rdy) begin
                m_nb = 0;
                m_rdy = 1'b0;
            end
        end else if (rx_rdy) begin
            m_cmd[23-8*eff -: 8] = rx_data;
            m_nb   = eff + 1;
            m_last = cyc;
            if (m_nb == 3) m_rdy = 1'b1;
            void'(rxq.pop_front());
        end else begin
            m_nb = eff;
        end

        accept   = send_resp && (m_pend.size() == 0 || !m_busy);
        launched = 1'b0;
        direct   = 1'b0;
        lval     = 8'h00;
        if (!m_busy) begin
            if (m_pend.size() > 0) begin
                lval = m_pend.pop_front();
                launched = 1'b1;
            end else if (send_resp) begin
                lval = resp_data;
                launched = 1'b1;
                direct = 1'b1;
            end
        end
        if (accept && !direct) m_pend.push_back(resp_data);
        if (send_resp && !accept) m_ovf = 1'b1;
        if (launched) begin
            m_busy = 1'b1;
            m_tx   = lval;
        end else if (m_busy && tx_done) begin
            m_busy = 1'b0;
        end
        m_trmt = launched;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
        rxq.delete();
        #2;
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_trmt", 32'(trmt), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_resp_ovf", 32'(resp_ovf), 32'h0);
        chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic release_cmd();
        clr_cmd_rdy = 1'b1;
        cycle();
        clr_cmd_rdy = 1'b0;
        cycle();
    endtask

    task automatic drain_tx();
        for (int i = 0; i < 40 && (m_busy || m_pend.size() > 0); i++) begin
            tx_done = m_busy;
            cycle();
        end
        tx_done = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Three bytes with short gaps.
        n_clr = 0;
        rxq.push_back(8'h02); run(3);
        rxq.push_back(8'h1D); run(5);
        rxq.push_back(8'h00); run(3);
        chk("lit_cmd_021D00", 32'(cmd), 32'h0002_1D00);
        chk("lit_cmd_rdy_1", 32'(cmd_rdy), 32'h1);
        chk("lit_clr_pulses", 32'(n_clr), 32'd3);
        release_cmd();

        // Partial command abandoned after a long idle gap.
        rxq.push_back(8'h03); run(1);
        run(T + 5);
        rxq.push_back(8'h07); run(2);
        rxq.push_back(8'h00); run(1);
        rxq.push_back(8'h00); run(3);
        chk("lit_cmd_070000", 32'(cmd), 32'h0007_0000);
        chk("lit_cmd_rdy_2", 32'(cmd_rdy), 32'h1);
        release_cmd();

        // Timeout boundary: T-1 gap still continues, T gap restarts.
        rxq.push_back(8'hAA); run(1);
        run(T - 2);
        rxq.push_back(8'hBB); run(1);
        run(T - 1);
        rxq.push_back(8'hCC); run(1);
        rxq.push_back(8'hDD); run(1);
        rxq.push_back(8'hEE); run(3);
        chk("lit_cmd_CCDDEE", 32'(cmd), 32'h00CC_DDEE);
        release_cmd();

        // Byte arriving while a command is held waits for release.
        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33); run(5);
        n_clr = 0;
        rxq.push_back(8'h09); run(6);
        chk("lit_hold_no_clr", 32'(n_clr), 32'h0);
        chk("lit_hold_cmd", 32'(cmd), 32'h0011_2233);
        release_cmd();
        rxq.push_back(8'h44); rxq.push_back(8'h55); run(4);
        chk("lit_cmd_094455", 32'(cmd), 32'h0009_4455);
        release_cmd();

        // Two responses, second queued behind the first.
        trmt_log.delete(); n_sent = 0;
        send_resp = 1'b1; resp_data = 8'hA5; cycle();
        send_resp = 1'b0; cycle();
        send_resp = 1'b1; resp_data = 8'h5A; cycle();
        send_resp = 1'b0; run(2);
        tx_done = 1'b1; cycle();
        tx_done = 1'b0; run(2);
        tx_done = 1'b1; cycle();
        tx_done = 1'b0; run(2);
        chk("lit_trmt_count", 32'(trmt_log.size()), 32'd2);
        if (trmt_log.size() >= 2) begin
            chk("lit_trmt_0", 32'(trmt_log[0]), 32'hA5);
            chk("lit_trmt_1", 32'(trmt_log[1]), 32'h5A);
        end
        chk("lit_resp_sent_count", 32'(n_sent), 32'd2);
        chk("lit_ovf_0", 32'(resp_ovf), 32'h0);

        // Third request while busy with a full pending slot is dropped.
        send_resp = 1'b1; resp_data = 8'hB1; cycle();
        resp_data = 8'hB2; cycle();
        resp_data = 8'hB3; cycle();
        send_resp = 1'b0; cycle();
        chk("lit_ovf_1", 32'(resp_ovf), 32'h1);
        drain_tx();

        // Reset mid-command and mid-transmit, then a clean command.
        rxq.push_back(8'h61); rxq.push_back(8'h62); run(2);
        send_resp = 1'b1; resp_data = 8'hC3; cycle();
        send_resp = 1'b0;
        do_reset();
        run(2);
        rxq.push_back(8'h71); rxq.push_back(8'h72); rxq.push_back(8'h73); run(5);
        chk("lit_cmd_717273", 32'(cmd), 32'h0071_7273);
        release_cmd();

        // Randomized traffic on both paths, alternating fast and slow byte arrival.
        for (int i = 0; i < 4000; i++) begin
            logic slow;
            slow = ((i / 400) % 2) == 1;
            if (rxq.size() < 2) begin
                if (slow ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0))
                    rxq.push_back(8'($urandom));
            end
            clr_cmd_rdy = ($urandom_range(0, 7) == 0);
            send_resp   = ($urandom_range(0, 3) == 0);
            resp_data   = 8'($urandom);
            tx_done     = m_busy && ($urandom_range(0, 2) == 0);
            cycle();
        end
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        drain_tx();
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000: idle clocks allowed between bytes of one command before partial-command discard.
REQ-002 clk  in  1  system clock, all flops on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rx_rdy  in  1  UART receiver holds a byte; stays high until clr_rx_rdy.
REQ-005 rx_data  in  8  received byte, valid while rx_rdy high.
REQ-006 clr_rx_rdy  out  1  one-cycle pulse consuming the current rx byte.
REQ-007 cmd  out  24  assembled command: byte1 in [23:16], byte2 in [15:8], byte3 in [7:0].
REQ-008 cmd_rdy  out  1  cmd valid and stable, level.
REQ-009 clr_cmd_rdy  in  1  command decoder releases cmd.
REQ-010 send_resp  in  1  one-cycle request to transmit resp_data.
REQ-011 resp_data  in  8  response byte, sampled when send_resp high.
REQ-012 resp_sent  out  1  one-cycle pulse when a response byte has finished transmitting.
REQ-013 trmt  out  1  one-cycle pulse starting UART transmit of tx_data.
REQ-014 tx_data  out  8  byte to transmit, held stable from trmt until tx_done.
REQ-015 tx_done  in  1  UART transmitter finished, one-cycle pulse.
REQ-016 resp_ovf  out  1  sticky flag: a response request was dropped.

Function
REQ-017 RX FSM states WAIT_B1, WAIT_B2, WAIT_B3, HOLD; reset state WAIT_B1.
REQ-018 In WAIT_Bn with rx_rdy high: latch rx_data into byte n of cmd, pulse clr_rx_rdy in the same cycle, advance (WAIT_B3 goes to HOLD).
REQ-019 cmd_rdy is registered: rises in the cycle after the third byte is latched, stays high through HOLD.
REQ-020 In HOLD, rx_rdy is not consumed (clr_rx_rdy low); pending bytes stay in the receiver.
REQ-021 HOLD with clr_cmd_rdy: cmd_rdy falls next cycle, go to WAIT_B1; cmd keeps its last value.
REQ-022 clr_cmd_rdy outside HOLD has no effect.
REQ-023 Timeout counter clears on every accepted byte and increments each cycle in WAIT_B2/WAIT_B3.
REQ-024 Counter reaching TIMEOUT_CYC-1: return to WAIT_B1, discard partial bytes, no cmd_rdy.
REQ-025 rx_rdy in the same cycle as timeout: the byte is taken as byte1 of a new command.
REQ-026 Counter is width $clog2(TIMEOUT_CYC) and never wraps.
REQ-027 TX side has TX_IDLE and TX_BUSY plus a one-entry pending buffer (pend_vld, pend_data).
REQ-028 send_resp with pend_vld low: write resp_data into the pending buffer.
REQ-029 send_resp with pend_vld high and no pop that cycle: drop the request and set resp_ovf.
REQ-030 TX_IDLE with pend_vld: move pend_data to tx_data, pulse trmt, clear pend_vld, go TX_BUSY.
REQ-031 Minimum latency from send_resp (idle, empty) to trmt is 1 cycle.
REQ-032 TX_BUSY with tx_done: pulse resp_sent the same cycle, go TX_IDLE; a pending byte launches the next cycle.
REQ-033 send_resp in the same cycle the buffer is popped is accepted, not dropped.
REQ-034 RX and TX paths are independent and may be active simultaneously.

Reset
REQ-035 On rst_n low, asynchronously:
- RX state WAIT_B1, TX state TX_IDLE.
- cmd=24'h000000, tx_data=8'h00.
- cmd_rdy, clr_rx_rdy, trmt, resp_sent, resp_ovf, pend_vld all 0.
- Timeout counter 0.
REQ-036 Reset mid-command or mid-transmit abandons all work; no pulses on release.

Structure
REQ-037 RX and TX state enums go in shared package cmd_pkg, beside the command opcode constants.
REQ-038 TX side (REQ-027..033) is one sub-module, resp_queue; RX assembly and timeout stay in the top module.
REQ-039 All outputs are driven from flops except clr_rx_rdy and resp_sent, which are combinational from state and inputs.

Verification
REQ-040 Bytes 02,1D,00 with gaps under the timeout -> cmd=24'h021D00, cmd_rdy high, 3 clr_rx_rdy pulses.
REQ-041 Byte 03, then 1_000_000 idle clocks, then 07,00,00 -> cmd=24'h070000, the 03 never appears in cmd.
REQ-042 cmd_rdy high and byte 09 arrives -> no clr_rx_rdy until clr_cmd_rdy; then 09 is taken as byte1.
REQ-043 send_resp A5 then send_resp 5A while busy, then tx_done twice -> trmt A5 then 5A, 2 resp_sent pulses, resp_ovf=0.
REQ-044 Three send_resp while the first is busy -> third dropped, resp_ovf=1.
REQ-045 rst_n low after byte2 -> state WAIT_B1, cmd=0; a fresh 3-byte sequence assembles correctly.
